// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store, programmable wait states,
// valid/ready request and response. Define DMEM_OOR_ERR_EN to flag out-of-range addresses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    state_t          state, state_nx;
    logic [3:0]      wait_cnt;
    dmem_req_t       lat_req, cur_req;
    logic            accept, commit, acc_err;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic [3:0][7:0] wdat, rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_data;

    // In IDLE the live request is used directly so a zero-wait access can commit on its accept edge.
    assign cur_req = (state == IDLE) ? {req_we, req_funct3, req_addr, req_wdata} : lat_req;
    assign accept  = req_valid & req_ready;
    assign commit  = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd0));
    assign idx     = cur_req.addr[AW+1:2];

    always_comb begin
        acc_err = 1'b0;
        if (cur_req.funct3[1:0] == 2'b01 && cur_req.addr[0])          acc_err = 1'b1;
        if (cur_req.funct3[1:0] == 2'b10 && cur_req.addr[1:0] != 2'b00) acc_err = 1'b1;
        if (cur_req.we) begin
            if (cur_req.funct3 >= 3'b011) acc_err = 1'b1;
        end else if (cur_req.funct3 == 3'b011 || cur_req.funct3 == 3'b110 ||
                     cur_req.funct3 == 3'b111) begin
            acc_err = 1'b1;
        end
`ifdef DMEM_OOR_ERR_EN
        if (cur_req.addr[31:AW+2] != '0) acc_err = 1'b1;
`endif
    end

`ifndef DMEM_OOR_ERR_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^cur_req.addr[31:AW+2];
`endif

    // Store data is replicated across lanes; the byte enables pick the lanes that land.
    always_comb begin
        be   = 4'b1111;
        wdat = cur_req.wdata;
        case (cur_req.funct3[1:0])
            2'b00: begin
                be   = 4'b0001 << cur_req.addr[1:0];
                wdat = {4{cur_req.wdata[7:0]}};
            end
            2'b01: begin
                be   = cur_req.addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{cur_req.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        always_ff @(posedge clk) begin
            if (commit && !rst && cur_req.we && !acc_err && be[l])
                lane_mem[idx] <= wdat[l];
        end
        assign rd_word[l] = lane_mem[idx];
    end

    assign rd_byte = rd_word[cur_req.addr[1:0]];
    assign rd_half = cur_req.addr[1] ? rd_word[3:2] : rd_word[1:0];

    always_comb begin
        load_data = '0;
        if (!acc_err && !cur_req.we) begin
            case (cur_req.funct3)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  load_data = {24'd0, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b101:  load_data = {16'd0, rd_half};
                3'b010:  load_data = rd_word;
                default: load_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            lat_req    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_req  <= cur_req;
                wait_cnt <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                resp_rdata <= load_data;
                resp_err   <= acc_err;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan steps plus random traffic against a byte-array model.
module tb_dmem_responder;
    localparam int DW = 1024;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [0:DW*4-1];
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Little-endian byte memory; access size and signedness come straight from funct3.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int size = 4;
        bit uns = 1'b0;
        bit legal = 1'b1;
        int base;
        logic [31:0] v;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; legal = !we; end
            3'd5: begin size = 2; uns = 1'b1; legal = !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || ((a % size) != 0);
`ifdef DMEM_OOR_ERR_EN
        err = err || (a >= 32'(DW * 4));
`endif
        base = int'(a % 32'(DW * 4));
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
                if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endfunction

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int stall);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model(we, f3, a, wd, exp_rd, exp_err);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom_range(0, 7));
        n = 1;
        while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("latency", 32'(n), 32'(WS + 1));
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", resp_rdata, exp_rd);
            check("stall_err", 32'(resp_err), 32'(exp_err));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        last_rdata = resp_rdata;
        last_err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_err", 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] hi;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed plan
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 0);
        check("lw_10", last_rdata, 32'hDEADBEEF);
        txn(1'b0, 3'b000, 32'h13, 32'd0, 1);
        check("lb_13", last_rdata, 32'hFFFFFFDE);
        txn(1'b0, 3'b100, 32'h13, 32'd0, 0);
        check("lbu_13", last_rdata, 32'h000000DE);
        txn(1'b0, 3'b001, 32'h12, 32'd0, 0);
        check("lh_12", last_rdata, 32'hFFFFDEAD);
        txn(1'b0, 3'b101, 32'h10, 32'd0, 2);
        check("lhu_10", last_rdata, 32'h0000BEEF);
        txn(1'b1, 3'b000, 32'h11, 32'h55, 0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 0);
        check("lw_after_sb", last_rdata, 32'hDEAD55EF);
        txn(1'b0, 3'b010, 32'h12, 32'd0, 0);
        check("lw_mis_err", 32'(last_err), 32'd1);
        txn(1'b1, 3'b001, 32'h11, 32'hFFFF, 0);
        check("sh_mis_err", 32'(last_err), 32'd1);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 5);
        check("lw_no_write", last_rdata, 32'hDEAD55EF);

        // Reset while a store waits: the store must never land
        txn(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_no_valid", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_rdata", resp_rdata, 32'd0);
        check("midrst_err", 32'(resp_err), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle", 32'(req_ready), 32'd1);
        txn(1'b0, 3'b010, 32'h20, 32'd0, 0);
        check("lw_20_prior", last_rdata, 32'hCAFEF00D);

        // Fill a small window so every random load hits known data
        for (int w = 0; w < 16; w++) txn(1'b1, 3'b010, 32'(w * 4), $urandom, 0);

        for (int k = 0; k < 80; k++) begin
            hi = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_F000) : 32'd0;
            a  = hi | 32'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                int'($urandom_range(0, 3)));
        end

`ifdef DMEM_OOR_ERR_EN
        txn(1'b0, 3'b010, 32'h1000, 32'd0, 0);
        check("oor_err", 32'(last_err), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
